// File: rtl/uart_tx_core.sv
// UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) pacing an upstream
// byte sequencer through a busy/done handshake. tx, busy and done derive only from registers.
module uart_tx_core #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP  = 3'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_done;

  // Handshake: en is a level request sampled only while idle; done pulses in the
  // final clock of the stop bit, after which the next byte may be presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (en) begin
            r_shift <= data;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= ^r_shift;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
              r_tx  <= r_shift[r_idx + 3'd1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            // Set one clock early so the registered pulse lands on the last stop clock.
            r_done <= (r_cnt == PRE_LAST);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx        = r_tx;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: drivers push expected bytes, a line monitor
// captures each frame from tx/busy/done and compares it against an ideal frame.
module tb_uart_tx_core;

  localparam int N = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * N;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  uart_tx_core #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk(clk), .rst(rst), .en(en), .data(data),
    .tx(tx), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor / scoreboard
  logic tx_s [FRAME];
  initial begin : monitor
    bit in_frame = 0;
    int pos = 0;
    bit busy_bad = 0;
    int done_cnt = 0;
    bit done_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (in_frame) begin
          in_frame = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        check(tx === 1'b1 && busy === 1'b0 && done === 1'b0, "reset_outputs", {tx, busy, done}, 3'b100);
      end else begin
        if (!in_frame && busy === 1'b1) begin
          in_frame = 1; pos = 0; busy_bad = 0; done_cnt = 0; done_last = 0;
        end
        if (!in_frame) begin
          check(tx === 1'b1 && done === 1'b0, "idle_line", {tx, done}, 2'b10);
        end else begin
          tx_s[pos] = tx;
          if (busy !== 1'b1) busy_bad = 1;
          if (done === 1'b1) begin
            done_cnt++;
            if (pos == FRAME - 1) done_last = 1;
          end
          pos++;
          if (pos == FRAME) begin
            logic [7:0] b;
            logic [NBITS-1:0] bits;
            int bad;
            in_frame = 0;
            if (exp_q.size() == 0) begin
              check(0, "unexpected_frame", 0, 1);
            end else begin
              b = exp_q.pop_front();
              bits = '1;
              bits[0] = 1'b0;
              for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
              bits[9] = ^b;
`endif
              bad = 0;
              for (int p = 0; p < FRAME; p++)
                if (tx_s[p] !== bits[p / N]) bad++;
              check(bad == 0, "frame_bits", bad, 0);
              b = '0;
              for (int i = 0; i < 8; i++) b[i] = tx_s[(i + 1) * N + N / 2];
              check(bad == 0, "frame_byte", b, bits[8:1]);
`ifdef UART_TX_PARITY_EN
              check(tx_s[9 * N + N / 2] === bits[9], "parity_bit", tx_s[9 * N + N / 2], bits[9]);
`endif
            end
            check(!busy_bad, "busy_span", busy_bad, 0);
            check(done_cnt == 1 && done_last, "done_pulse", done_cnt, 1);
          end
        end
      end
    end
  end

  // drivers
  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < 2 * FRAME);
    if (busy !== 1'b0) check(0, "idle_timeout", busy, 0);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1;
        return;
      end
    end
    check(0, "done_timeout", 0, 1);
  endtask

  task automatic send_pulse(input logic [7:0] b);
    wait_idle();
    data = b;
    en = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    en = 1'b0;
    data = 8'($urandom);
  endtask

  task automatic run_burst(input logic [7:0] b [8], input int n);
    bit ok;
    wait_idle();
    data = b[0];
    en = 1'b1;
    exp_q.push_back(b[0]);
    for (int i = 0; i < n; i++) begin
      wait_done(ok);
      if (!ok) break;
      if (i + 1 < n) begin
        data = b[i + 1];
        exp_q.push_back(b[i + 1]);
        @(negedge clk);
        check(busy === 1'b0, "gap_idle", busy, 0);
        @(negedge clk);
        check(busy === 1'b1, "gap_restart", busy, 1);
      end
    end
    en = 1'b0;
  endtask

  initial begin : stimulus
    logic [7:0] seq [8];
    bit ok;
    rst = 1'b1;
    en = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_pulse(8'hA5);
    send_pulse(8'h07);
    send_pulse(8'h03);

    // en held; data changes mid-frame and must not corrupt the frame in flight
    wait_idle();
    data = 8'hA5;
    en = 1'b1;
    exp_q.push_back(8'hA5);
    repeat (40) @(negedge clk);
    data = 8'h3C;
    exp_q.push_back(8'h3C);
    wait_done(ok);
    @(negedge clk);
    check(busy === 1'b0 && tx === 1'b1, "b2b_gap", {busy, tx}, 2'b01);
    wait_done(ok);
    en = 1'b0;

    seq = '{8'h30, 8'h59, 8'h12, 8'h15, 8'h08, 8'h02, 8'h24, 8'h00};
    run_burst(seq, 7);
    @(negedge clk);
    @(negedge clk);
    check(busy === 1'b0, "burst_end_idle", busy, 0);

    // abandon a frame during data bit 3
    send_pulse(8'hC3);
    repeat (4 * N + 5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check(tx === 1'b1 && busy === 1'b0, "async_reset", {tx, busy}, 2'b10);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_pulse(8'h55);

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        send_pulse(8'($urandom));
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end else begin
        for (int j = 0; j < 8; j++) seq[j] = 8'($urandom);
        run_burst(seq, $urandom_range(2, 3));
      end
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #(2000000);
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- 8N1 UART transmitter sitting directly downstream of the RTC byte sequencer.
- The sequencer holds `en` high with a byte on `data` and advances to its next byte on the `done` pulse. It returns to idle when `busy` drops.
- This block serialises each accepted byte onto the `tx` line at a fixed baud rate. It provides the `busy`/`done` handshake that paces the sequencer.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- CLKS_PER_BIT (localparam), CLK_HZ/BAUD (integer division), clocks per bit; required to be >= 2. Baud counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  transmit request, level-sensitive; sampled only in IDLE.
- data  input  8  byte to send; latched on the accept cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-clock pulse marking the end of a frame.

Behaviour:
- Reset values (async, take effect immediately):
  - state=IDLE, tx=1, busy=0, done=0.
  - baud counter=0, bit index=0, shift register=0.
- States: IDLE, START, DATA, STOP (plus PARITY when enabled).
- IDLE:
  - tx=1, busy=0.
  - If en=1 on a rising edge: latch data into the shift register, clear the baud counter, go to START.
  - tx falls on that same edge. Latency from sampled en to start bit is 1 clock.
- START: tx=0 for CLKS_PER_BIT clocks, then go to DATA with bit index=0.
- DATA:
  - tx = shift[bit index], LSB first; each bit lasts CLKS_PER_BIT clocks.
  - After bit 7: go to STOP (or PARITY if enabled).
- STOP: tx=1 for CLKS_PER_BIT clocks, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit and wraps to 0 on every bit boundary.
  - Bit and state advance when counter==CLKS_PER_BIT-1.
- busy:
  - 1 in START/DATA/PARITY/STOP, including the done cycle; 0 in IDLE.
  - Decoded from registered state only.
- done:
  - High for exactly the final clock of STOP (counter==CLKS_PER_BIT-1), i.e. the clock on whose edge state returns to IDLE.
  - Never asserted outside that clock.
  - No combinational path from any input to done, busy or tx.
- tx is glitch-free: driven from a register or registered-state decode.
- While busy, en and data are ignored; data may change freely without corrupting the frame.
- Back-to-back operation:
  - If en is still high in the IDLE clock after done, the next frame starts.
  - This gives exactly one extra idle-high clock between frames; effective stop length is CLKS_PER_BIT+1 clocks.
  - The sequencer presents the next byte in that clock, so the byte accepted is the new one.
- Frame duration: 10*CLKS_PER_BIT clocks from the start-bit edge to the IDLE return.
- Reset mid-frame: the frame is abandoned, tx=1 immediately, no done pulse. After release the block behaves as from power-up.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, lasting CLKS_PER_BIT clocks.
  - tx = XOR of the 8 latched data bits (even parity).
  - Frame = 11*CLKS_PER_BIT clocks.
  - busy covers PARITY; done timing is unchanged relative to STOP.
- Undefined: no PARITY state, 8N1 framing, zero parity logic.

Test Plan:
- Power-up with rst=1 for 3 clocks, en=0 -> tx=1, busy=0, done=0 throughout and after release.
- CLK_HZ=16, BAUD=1 (CLKS_PER_BIT=16); data=0xA5 with en pulsed 1 clock:
  - tx bits 0,1,0,1,0,0,1,0,1,1, each 16 clocks.
  - busy high 160 clocks.
  - Single done pulse on clock 160 after accept.
- en held high, data=0xA5 accepted, then data changed to 0x3C at clock 40:
  - First frame still transmits 0xA5.
  - After done: one idle-high clock, then a 0x3C frame starts.
- Sequencer-style burst, 7 bytes 0x30,0x59,0x12,0x15,0x08,0x02,0x24, each advanced on done:
  - 7 frames in order, 7 done pulses.
  - Exactly 1 idle clock between frames.
  - busy low after the 7th frame.
- rst asserted during DATA bit 3 -> tx=1 and busy=0 in the same cycle, no done. After release, en with 0x55 produces a clean full frame.
- UART_TX_PARITY_EN defined, data=0x07 -> parity bit=1, frame 176 clocks, done on clock 176. With data=0x03 -> parity bit=0.
